// File: rtl/i2c_seq_pkg.sv
// ============================================================================
// Module : i2c_seq_pkg
// Brief  : I2C core register map, command/status constants and sequencer states
// Rev    : 1.0
// ============================================================================
`default_nettype none

package i2c_seq_pkg;

  localparam logic [7:0] c_ADDR_SADDR  = 8'h00;
  localparam logic [7:0] c_ADDR_TXDATA = 8'h04;
  localparam logic [7:0] c_ADDR_CMD    = 8'h08;
  localparam logic [7:0] c_ADDR_STATUS = 8'h0C;
  localparam logic [7:0] c_ADDR_RXDATA = 8'h10;

  localparam logic [7:0] c_CMD_START   = 8'h01;
  localparam logic [7:0] c_STAT_BUSY   = 8'h01;
  localparam logic [7:0] c_STAT_NACK   = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARB      = 3'd1,
    ST_WR_SADDR = 3'd2,
    ST_WR_TX    = 3'd3,
    ST_WR_CMD   = 3'd4,
    ST_POLL     = 3'd5,
    ST_RD_RX    = 3'd6,
    ST_FINISH   = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_rr_arbiter.sv
// ============================================================================
// Module : i2c_rr_arbiter
// Brief  : Round-robin arbiter; search begins at i_ptr and wraps around
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2c_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PW      = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PW-1:0]      o_idx,
  output logic               o_valid
);

  always_comb begin
    int k;
    k       = 0;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(i_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!o_valid && i_req[PW'(k)]) begin
        o_gnt[PW'(k)] = 1'b1;
        o_idx         = PW'(k);
        o_valid       = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_apb_sequencer.sv
// ============================================================================
// Module : i2c_apb_sequencer
// Brief  : Arbitrates requesters and drives an I2C core over APB per transfer
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2c_apb_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int POLL_TIMEOUT = 1023
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [NUM_REQ*7-1:0] req_saddr,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic [7:0]           paddr_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [7:0]           pwdata_o,
  input  logic [7:0]           prdata_i,
  input  logic                 pready_i
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(POLL_TIMEOUT + 1);

  state_t             r_state;
  state_t             w_next_state;
  logic               r_phase;
  logic [NUM_REQ-1:0] r_gnt;
  logic [PW-1:0]      r_ptr;
  logic               r_rw;
  logic [6:0]         r_saddr;
  logic [7:0]         r_wdata;
  logic [CW-1:0]      r_poll_cnt;
  logic               r_err;
  logic [7:0]         r_rdata;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [PW-1:0]      w_arb_idx;
  logic               w_arb_valid;
  logic               w_apb_state;
  logic               w_xfer_done;
  logic               w_fin_err;

  i2c_rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_apb_state = r_state inside {ST_WR_SADDR, ST_WR_TX, ST_WR_CMD, ST_POLL, ST_RD_RX};
  assign w_xfer_done = w_apb_state && r_phase && pready_i;

  // r_phase: 0 = SETUP, 1 = ACCESS (held while the core stalls)
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= ST_IDLE;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_phase <= w_apb_state ? (r_phase ? !pready_i : 1'b1) : 1'b0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_fin_err    = 1'b0;
    case (r_state)
      ST_IDLE:     if (|req) w_next_state = ST_ARB;
      ST_ARB:      w_next_state = w_arb_valid ? ST_WR_SADDR : ST_IDLE;
      ST_WR_SADDR: if (w_xfer_done) w_next_state = r_rw ? ST_WR_CMD : ST_WR_TX;
      ST_WR_TX:    if (w_xfer_done) w_next_state = ST_WR_CMD;
      ST_WR_CMD:   if (w_xfer_done) w_next_state = ST_POLL;
      ST_POLL: begin
        if (w_xfer_done) begin
          if ((prdata_i & c_STAT_BUSY) == 8'h00) begin
            if ((prdata_i & c_STAT_NACK) != 8'h00) begin
              w_next_state = ST_FINISH;
              w_fin_err    = 1'b1;
            end else begin
              w_next_state = r_rw ? ST_RD_RX : ST_FINISH;
            end
          end else if (r_poll_cnt == CW'(POLL_TIMEOUT - 1)) begin
            w_next_state = ST_FINISH;
            w_fin_err    = 1'b1;
          end
        end
      end
      ST_RD_RX:    if (w_xfer_done) w_next_state = ST_FINISH;
      ST_FINISH:   w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // Requester fields are snapshotted at grant so later changes cannot disturb the sequence
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_gnt      <= '0;
      r_ptr      <= '0;
      r_rw       <= 1'b0;
      r_saddr    <= '0;
      r_wdata    <= '0;
      r_poll_cnt <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_err <= w_fin_err;
      if (r_state == ST_ARB && w_arb_valid) begin
        r_gnt      <= w_arb_gnt;
        r_ptr      <= (int'(w_arb_idx) == NUM_REQ - 1) ? '0 : w_arb_idx + 1'b1;
        r_rw       <= req_rw[w_arb_idx];
        r_saddr    <= req_saddr[int'(w_arb_idx)*7 +: 7];
        r_wdata    <= req_wdata[int'(w_arb_idx)*8 +: 8];
        r_poll_cnt <= '0;
      end
      if (r_state == ST_POLL && w_xfer_done) r_poll_cnt <= r_poll_cnt + 1'b1;
      if (r_state == ST_RD_RX && w_xfer_done) r_rdata <= prdata_i;
    end
  end

  always_comb begin
    gnt       = '0;
    done      = '0;
    err       = 1'b0;
    psel_o    = w_apb_state;
    penable_o = w_apb_state && r_phase;
    paddr_o   = '0;
    pwrite_o  = 1'b0;
    pwdata_o  = '0;
    case (r_state)
      ST_WR_SADDR: begin paddr_o = c_ADDR_SADDR;  pwrite_o = 1'b1; pwdata_o = {r_saddr, r_rw}; end
      ST_WR_TX:    begin paddr_o = c_ADDR_TXDATA; pwrite_o = 1'b1; pwdata_o = r_wdata; end
      ST_WR_CMD:   begin paddr_o = c_ADDR_CMD;    pwrite_o = 1'b1; pwdata_o = c_CMD_START; end
      ST_POLL:     paddr_o = c_ADDR_STATUS;
      ST_RD_RX:    paddr_o = c_ADDR_RXDATA;
      default:     ;
    endcase
    if (r_state != ST_IDLE && r_state != ST_ARB) gnt = r_gnt;
    if (r_state == ST_FINISH) begin
      done = r_gnt;
      err  = r_err;
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_i2c_apb_sequencer.sv
// ============================================================================
// Module : tb_i2c_apb_sequencer
// Brief  : Self-checking bench with an APB slave model and transfer reference model
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_apb_sequencer;

  localparam int N  = 2;
  localparam int TO = 4;

  typedef logic [16:0] acc_t;  // {write, addr, data}

  logic           pclk = 1'b0;
  logic           preset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_rw = '0;
  logic [N*7-1:0] req_saddr = '0;
  logic [N*8-1:0] req_wdata = '0;
  logic [N-1:0]   gnt, done;
  logic           err, psel_o, penable_o, pwrite_o;
  logic [7:0]     rdata, paddr_o, pwdata_o;
  logic [7:0]     prdata_i = 8'h00;
  logic           pready_i = 1'b0;

  int         n_checks = 0;
  int         n_fail   = 0;
  acc_t       act_q[$];
  acc_t       exp_q[$];
  logic [7:0] status_q[$];
  bit         stuck_busy = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  int         cfg_wait = 0;
  int         wcnt = 0;
  logic [16:0] setup_snap = '0;

  i2c_apb_sequencer #(.NUM_REQ(N), .POLL_TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset), .req(req), .req_rw(req_rw),
    .req_saddr(req_saddr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .paddr_o(paddr_o), .psel_o(psel_o),
    .penable_o(penable_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 pclk = ~pclk;

  // Slave: ready after cfg_wait stalled ACCESS cycles, STATUS from status_q
  always @(posedge pclk) begin
    #1;
    if (psel_o && penable_o) begin
      pready_i = (wcnt >= cfg_wait);
      wcnt++;
    end else begin
      pready_i = 1'b0;
      wcnt = 0;
    end
    if (paddr_o == 8'h0C)
      prdata_i = stuck_busy ? 8'h01 : (status_q.size() > 0 ? status_q[0] : 8'h00);
    else if (paddr_o == 8'h10)
      prdata_i = rx_byte;
    else
      prdata_i = 8'h00;
  end

  always @(negedge pclk) begin
    if (psel_o && !penable_o) setup_snap = {pwrite_o, paddr_o, pwdata_o};
    if (psel_o && penable_o) begin
      n_checks++;
      if ({pwrite_o, paddr_o, pwdata_o} !== setup_snap) begin
        n_fail++;
        $display("FAIL apb_stable: access %h setup %h", {pwrite_o, paddr_o, pwdata_o}, setup_snap);
      end
      if (pready_i) begin
        act_q.push_back({pwrite_o, paddr_o, pwrite_o ? pwdata_o : prdata_i});
        if (!pwrite_o && paddr_o == 8'h0C && !stuck_busy && status_q.size() > 0)
          void'(status_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Reference model: expected APB access list and outcome from the register protocol
  task automatic model(input bit rw, input logic [6:0] sa, input logic [7:0] wd,
                       output bit e, output logic [7:0] rd);
    logic [7:0] sq[$];
    logic [7:0] s;
    sq = status_q;
    exp_q.delete();
    e  = 1'b0;
    rd = 8'h00;
    exp_q.push_back({1'b1, 8'h00, sa, rw});
    if (!rw) exp_q.push_back({1'b1, 8'h04, wd});
    exp_q.push_back({1'b1, 8'h08, 8'h01});
    for (int n = 1; n <= TO; n++) begin
      s = stuck_busy ? 8'h01 : (sq.size() > 0 ? sq.pop_front() : 8'h00);
      exp_q.push_back({1'b0, 8'h0C, s});
      if (!s[0]) begin
        if (s[1]) e = 1'b1;
        else if (rw) begin
          rd = rx_byte;
          exp_q.push_back({1'b0, 8'h10, rx_byte});
        end
        break;
      end else if (n == TO) e = 1'b1;
    end
  endtask

  task automatic do_xfer(input int idx, input bit rw, input logic [6:0] sa, input logic [7:0] wd,
                         input bit drop_early, output logic [N-1:0] d, output bit e,
                         output logic [7:0] rd, output bit to);
    act_q.delete();
    @(negedge pclk);
    req_rw[idx] = rw;
    req_saddr[idx*7 +: 7] = sa;
    req_wdata[idx*8 +: 8] = wd;
    req[idx] = 1'b1;
    d = '0; e = 1'b0; rd = 8'h00; to = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge pclk);
      if (drop_early && gnt != '0 && req[idx]) begin
        req[idx] = 1'b0;
        req_rw[idx] = ~rw;
        req_saddr[idx*7 +: 7] = ~sa;
        req_wdata[idx*8 +: 8] = ~wd;
      end
      if (done != '0) begin
        d = done; e = err; rd = rdata; to = 1'b0;
        break;
      end
    end
    req[idx] = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (2) @(negedge pclk);
    n_checks++;
    if ({gnt, done, err, rdata, paddr_o, psel_o, penable_o, pwrite_o, pwdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b done=%b err=%b rdata=%h paddr=%h psel=%b expected all zero",
               gnt, done, err, rdata, paddr_o, psel_o);
    end
    preset = 1'b0;
    repeat (3) @(negedge pclk);
    n_checks++;
    if ({gnt, done, psel_o} !== '0) begin
      n_fail++;
      $display("FAIL idle_quiet: got gnt=%b done=%b psel=%b expected 0", gnt, done, psel_o);
    end
  endtask

  task automatic test_write();
    logic [N-1:0] d; bit e, ee, to; logic [7:0] rd, er;
    status_q.delete(); status_q.push_back(8'h00); cfg_wait = 0;
    model(1'b0, 7'h50, 8'hA5, ee, er);
    do_xfer(0, 1'b0, 7'h50, 8'hA5, 1'b1, d, e, rd, to);
    n_checks++;
    if (d !== 2'b01 || e !== 1'b0 || to) begin
      n_fail++;
      $display("FAIL write_done: got done=%b err=%b to=%0d expected done=01 err=0", d, e, to);
    end
    n_checks++;
    if (act_q.size() != 4 || act_q[0] !== {1'b1, 8'h00, 8'hA0}) begin
      n_fail++;
      $display("FAIL write_saddr: got n=%0d first=%h expected n=4 first=%h", act_q.size(),
               act_q.size() > 0 ? act_q[0] : 17'h0, {1'b1, 8'h00, 8'hA0});
    end
    n_checks++;
    if (act_q != exp_q) begin
      n_fail++;
      $display("FAIL write_seq: got %p expected %p", act_q, exp_q);
    end
  endtask

  task automatic test_read_poll();
    logic [N-1:0] d; bit e, ee, to; logic [7:0] rd, er;
    status_q = '{8'h01, 8'h01, 8'h00}; rx_byte = 8'h3C; cfg_wait = 0;
    model(1'b1, 7'h21, 8'h00, ee, er);
    do_xfer(1, 1'b1, 7'h21, 8'h00, 1'b0, d, e, rd, to);
    n_checks++;
    if (d !== 2'b10 || e !== 1'b0 || rd !== 8'h3C || to) begin
      n_fail++;
      $display("FAIL read_done: got done=%b err=%b rdata=%h expected done=10 err=0 rdata=3c", d, e, rd);
    end
    n_checks++;
    if (act_q != exp_q || act_q.size() != 6) begin
      n_fail++;
      $display("FAIL read_seq: got %p expected %p", act_q, exp_q);
    end
  endtask

  task automatic test_nack();
    logic [N-1:0] d; bit e, ee, to; logic [7:0] rd, er;
    status_q = '{8'h02}; rx_byte = 8'h77; cfg_wait = 1;
    model(1'b1, 7'h11, 8'h00, ee, er);
    do_xfer(0, 1'b1, 7'h11, 8'h00, 1'b0, d, e, rd, to);
    n_checks++;
    if (d !== 2'b01 || e !== 1'b1 || to) begin
      n_fail++;
      $display("FAIL nack_done: got done=%b err=%b expected done=01 err=1", d, e);
    end
    n_checks++;
    if (act_q != exp_q) begin
      n_fail++;
      $display("FAIL nack_seq: got %p expected %p", act_q, exp_q);
    end
  endtask

  task automatic test_timeout();
    logic [N-1:0] d; bit e, ee, to; logic [7:0] rd, er;
    int n_stat;
    status_q.delete(); stuck_busy = 1'b1; cfg_wait = 3;
    model(1'b0, 7'h0F, 8'h5A, ee, er);
    do_xfer(1, 1'b0, 7'h0F, 8'h5A, 1'b0, d, e, rd, to);
    n_stat = 0;
    foreach (act_q[i]) if (act_q[i][15:8] == 8'h0C) n_stat++;
    n_checks++;
    if (d !== 2'b10 || e !== 1'b1 || n_stat != TO || to) begin
      n_fail++;
      $display("FAIL timeout: got done=%b err=%b status_reads=%0d expected done=10 err=1 status_reads=%0d",
               d, e, n_stat, TO);
    end
    n_checks++;
    if (act_q != exp_q) begin
      n_fail++;
      $display("FAIL timeout_seq: got %p expected %p", act_q, exp_q);
    end
    stuck_busy = 1'b0; cfg_wait = 0;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] seen[$];
    int gaps[$];
    int last_done;
    logic [N-1:0] pg;
    preset = 1'b1; repeat (2) @(negedge pclk); preset = 1'b0;
    status_q.delete(); cfg_wait = 0; req_rw = '0;
    last_done = -1; pg = '0;
    req = 2'b11;
    for (int c = 0; c < 300 && seen.size() < 4; c++) begin
      @(negedge pclk);
      if (done != '0) begin
        seen.push_back(done);
        last_done = c;
      end else if (gnt != '0 && pg == '0 && last_done >= 0) gaps.push_back(c - last_done);
      pg = gnt;
    end
    req = '0;
    n_checks++;
    if (seen.size() != 4 || seen[0] !== 2'b01 || seen[1] !== 2'b10 || seen[2] !== 2'b01 || seen[3] !== 2'b10) begin
      n_fail++;
      $display("FAIL rr_order: got %p expected 01,10,01,10", seen);
    end
    n_checks++;
    if (gaps.size() != 3 || gaps[0] != 3 || gaps[1] != 3 || gaps[2] != 3) begin
      n_fail++;
      $display("FAIL rr_gap: got %p expected three gaps of 3 cycles", gaps);
    end
    repeat (3) @(negedge pclk);
  endtask

  task automatic test_random();
    logic [N-1:0] d, ed; bit e, ee, to; logic [7:0] rd, er;
    int idx, nb; bit rw; logic [6:0] sa; logic [7:0] wd;
    for (int it = 0; it < 12; it++) begin
      idx = $urandom_range(0, N - 1);
      rw = 1'($urandom_range(0, 1));
      sa = 7'($urandom); wd = 8'($urandom); rx_byte = 8'($urandom);
      cfg_wait = $urandom_range(0, 2);
      status_q.delete();
      nb = $urandom_range(0, 5);
      for (int b = 0; b < nb; b++) status_q.push_back(8'h01 | (8'($urandom) & 8'h02));
      status_q.push_back(($urandom_range(0, 3) == 0) ? 8'h02 : 8'h00);
      model(rw, sa, wd, ee, er);
      do_xfer(idx, rw, sa, wd, 1'($urandom_range(0, 1)), d, e, rd, to);
      ed = '0; ed[idx] = 1'b1;
      n_checks++;
      if (d !== ed || e !== ee || to || (rw && !ee && rd !== er)) begin
        n_fail++;
        $display("FAIL rand_result[%0d]: got done=%b err=%b rdata=%h to=%0d expected done=%b err=%b rdata=%h",
                 it, d, e, rd, to, ed, ee, er);
      end
      n_checks++;
      if (act_q != exp_q) begin
        n_fail++;
        $display("FAIL rand_seq[%0d]: got %p expected %p", it, act_q, exp_q);
      end
    end
    cfg_wait = 0;
  endtask

  task automatic test_reset_mid();
    bit hit, saw_done;
    status_q.delete(); cfg_wait = 6; hit = 1'b0; saw_done = 1'b0;
    @(negedge pclk);
    req_rw[0] = 1'b0; req_saddr[6:0] = 7'h33; req_wdata[7:0] = 8'hC3; req[0] = 1'b1;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge pclk);
      if (paddr_o == 8'h04 && penable_o) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL reset_mid_reach: got no TXDATA access expected one");
    end
    preset = 1'b1;
    @(negedge pclk);
    n_checks++;
    if ({gnt, done, err, rdata, paddr_o, psel_o, penable_o, pwrite_o, pwdata_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got gnt=%b done=%b rdata=%h paddr=%h psel=%b penable=%b expected all zero",
               gnt, done, rdata, paddr_o, psel_o, penable_o);
    end
    req = '0;
    @(negedge pclk); preset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge pclk);
      if (done != '0 || psel_o) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL reset_mid_nodone: got done or psel after reset expected none");
    end
    cfg_wait = 0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_poll();
    test_nack();
    test_timeout();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
